// File: rtl/multiplier_seq_ctrl.sv
// Column-serial sequencer for a 4x4 unsigned multiply built on an external
// partial-product unit (four 5:1 bit muxes ANDed with IB bits).
module multiplier_seq_ctrl #(
    parameter logic [2:0] CTRL_ZERO = 3'd4,
    parameter bit         PP_REG    = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic [3:0] a_in,
    input  logic [3:0] b_in,
    input  logic [3:0] pp_in,
    output logic [3:0] ia_out,
    output logic [3:0] ib_out,
    output logic [2:0] ctrl_b0,
    output logic [2:0] ctrl_b1,
    output logic [2:0] ctrl_b2,
    output logic [2:0] ctrl_b3,
    output logic       busy,
    output logic       done,
    output logic [7:0] product,
    output logic [1:0] state_dbg
);

    // Handshake: start is sampled only in IDLE (also in the cycle done is high);
    // done is a one-cycle pulse marking product valid, and product holds until
    // the next completion. abort cancels a running operation without done.

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_COL  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [2:0] col;
    logic [1:0] carry;
    logic [7:0] work;
    logic [3:0] pp_q;
    logic [3:0] pp_src;
    logic [2:0] sum;
    logic       last_col;
    logic       accept;

    // Lane i handles a[col-i]; out-of-range lanes select the constant-zero input.
    function automatic logic [2:0] lane_sel(input logic [2:0] c, input logic [2:0] lane);
        logic [2:0] d;
        d = c - lane;
        if (c >= lane && d <= 3'd3) return d;
        return CTRL_ZERO;
    endfunction

    always_comb begin
        pp_src   = PP_REG ? pp_q : pp_in;
        sum      = 3'(pp_src[0]) + 3'(pp_src[1]) + 3'(pp_src[2]) + 3'(pp_src[3]) + 3'(carry);
        last_col = (col == 3'd6);
        accept   = (state == S_IDLE) && start;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start) state_nxt = PP_REG ? S_WAIT : S_COL;
            S_COL: begin
                if (abort || last_col) state_nxt = S_IDLE;
                else                   state_nxt = PP_REG ? S_WAIT : S_COL;
            end
            S_WAIT: state_nxt = abort ? S_IDLE : S_COL;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col     <= 3'd0;
            carry   <= 2'd0;
            work    <= 8'd0;
            pp_q    <= 4'd0;
            ia_out  <= 4'd0;
            ib_out  <= 4'd0;
            product <= 8'd0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                ia_out <= a_in;
                ib_out <= b_in;
                col    <= 3'd0;
                carry  <= 2'd0;
                work   <= 8'd0;
            end else if (state != S_IDLE && abort) begin
                col   <= 3'd0;
                carry <= 2'd0;
            end else if (state == S_WAIT) begin
                pp_q <= pp_in;
            end else if (state == S_COL) begin
                work[col] <= sum[0];
                carry     <= sum[2:1];
                if (last_col) begin
                    // Column 6 also emits the final carry as bit 7.
                    product <= {sum[1], sum[0], work[5:0]};
                    done    <= 1'b1;
                    col     <= 3'd0;
                    carry   <= 2'd0;
                end else begin
                    col <= col + 3'd1;
                end
            end
        end
    end

    always_comb begin
        busy      = (state != S_IDLE);
        state_dbg = state;
        ctrl_b0   = CTRL_ZERO;
        ctrl_b1   = CTRL_ZERO;
        ctrl_b2   = CTRL_ZERO;
        ctrl_b3   = CTRL_ZERO;
        if (busy) begin
            ctrl_b0 = lane_sel(col, 3'd0);
            ctrl_b1 = lane_sel(col, 3'd1);
            ctrl_b2 = lane_sel(col, 3'd2);
            ctrl_b3 = lane_sel(col, 3'd3);
        end
    end

endmodule

// File: tb/tb_multiplier_seq_ctrl.sv
// Bench for multiplier_seq_ctrl: one instance per PP_REG setting, each wired to
// a behavioural model of the partial-product unit.
module tb_multiplier_seq_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start0, start1, abort0, abort1;
    logic [3:0] a, b;
    logic [3:0] pp0, pp1, ia0, ib0, ia1, ib1;
    logic [2:0] c00, c01, c02, c03, c10, c11, c12, c13;
    logic       busy0, done0, busy1, done1;
    logic [7:0] prod0, prod1;
    logic [1:0] st0, st1;

    logic       sel;
    logic       done_s, busy_s;
    logic [7:0] prod_s;

    int n_pass;
    int n_total;

    multiplier_seq_ctrl #(.CTRL_ZERO(3'd4), .PP_REG(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0),
        .a_in(a), .b_in(b), .pp_in(pp0), .ia_out(ia0), .ib_out(ib0),
        .ctrl_b0(c00), .ctrl_b1(c01), .ctrl_b2(c02), .ctrl_b3(c03),
        .busy(busy0), .done(done0), .product(prod0), .state_dbg(st0)
    );

    multiplier_seq_ctrl #(.CTRL_ZERO(3'd4), .PP_REG(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
        .a_in(a), .b_in(b), .pp_in(pp1), .ia_out(ia1), .ib_out(ib1),
        .ctrl_b0(c10), .ctrl_b1(c11), .ctrl_b2(c12), .ctrl_b3(c13),
        .busy(busy1), .done(done1), .product(prod1), .state_dbg(st1)
    );

    function automatic logic [3:0] pp_model(input logic [3:0] ia, input logic [3:0] ib,
                                            input logic [2:0] s0, input logic [2:0] s1,
                                            input logic [2:0] s2, input logic [2:0] s3);
        logic [3:0] r;
        r[0] = (s0 < 3'd4) ? (ia[s0[1:0]] & ib[0]) : 1'b0;
        r[1] = (s1 < 3'd4) ? (ia[s1[1:0]] & ib[1]) : 1'b0;
        r[2] = (s2 < 3'd4) ? (ia[s2[1:0]] & ib[2]) : 1'b0;
        r[3] = (s3 < 3'd4) ? (ia[s3[1:0]] & ib[3]) : 1'b0;
        return r;
    endfunction

    assign pp0    = pp_model(ia0, ib0, c00, c01, c02, c03);
    assign pp1    = pp_model(ia1, ib1, c10, c11, c12, c13);
    assign done_s = sel ? done1 : done0;
    assign busy_s = sel ? busy1 : busy0;
    assign prod_s = sel ? prod1 : prod0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Waits from the negedge after the accepting edge until done; cyc counts edges.
    task automatic wait_done(output int cyc, output int bcyc, output bit got);
        cyc = 0; bcyc = 0; got = 1'b0;
        while (cyc < 40) begin
            if (done_s) begin
                got = 1'b1;
                break;
            end
            if (busy_s) bcyc++;
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic pulse_start(input bit which, input logic [3:0] av, input logic [3:0] bv);
        @(negedge clk);
        sel = which; a = av; b = bv;
        if (which) start1 = 1'b1; else start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0; start1 = 1'b0;
    endtask

    task automatic run_op(input bit which, input logic [3:0] av, input logic [3:0] bv,
                          input logic [7:0] exp_p, input int exp_lat);
        int cyc, bcyc;
        bit got;
        pulse_start(which, av, bv);
        wait_done(cyc, bcyc, got);
        n_total++;
        if (!got) $display("FAIL done_timeout %0d*%0d: got no done, required done within 40", av, bv);
        else n_pass++;
        n_total++;
        if (cyc !== exp_lat) $display("FAIL latency %0d*%0d: got %0d required %0d", av, bv, cyc, exp_lat);
        else n_pass++;
        n_total++;
        if (prod_s !== exp_p) $display("FAIL product %0d*%0d: got %0d required %0d", av, bv, prod_s, exp_p);
        else n_pass++;
        n_total++;
        if (bcyc !== exp_lat || busy_s !== 1'b0)
            $display("FAIL busy_len %0d*%0d: got %0d (busy now %b) required %0d", av, bv, bcyc, busy_s, exp_lat);
        else n_pass++;
    endtask

    task automatic check_reset_vals(input string name);
        n_total++;
        if ({busy0, done0, prod0, ia0, ib0, st0} !== 20'd0)
            $display("FAIL %s_regs: got busy=%b done=%b prod=%0d ia=%0d ib=%0d st=%0d required all 0",
                     name, busy0, done0, prod0, ia0, ib0, st0);
        else n_pass++;
        n_total++;
        if ({c03, c02, c01, c00} !== {3'd4, 3'd4, 3'd4, 3'd4})
            $display("FAIL %s_ctrl: got %0d %0d %0d %0d required 4 4 4 4", name, c03, c02, c01, c00);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_vals("reset");
        n_total++;
        if ({busy1, done1, prod1, c13, c12, c11, c10} !== {10'd0, 3'd4, 3'd4, 3'd4, 3'd4})
            $display("FAIL reset_pp_reg: got busy=%b done=%b prod=%0d required 0 0 0", busy1, done1, prod1);
        else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        run_op(1'b0, 4'd15, 4'd15, 8'hE1, 7);
        n_total++;
        if ({c03, c02, c01, c00} !== {3'd4, 3'd4, 3'd4, 3'd4})
            $display("FAIL ctrl_idle_after_done: got %0d %0d %0d %0d required 4 4 4 4", c03, c02, c01, c00);
        else n_pass++;
        run_op(1'b0, 4'd3, 4'd5, 8'd15, 7);
        run_op(1'b0, 4'd0, 4'd9, 8'd0, 7);
        run_op(1'b0, 4'd9, 4'd1, 8'd9, 7);
    endtask

    task automatic test_exhaustive();
        logic [3:0] ai, bi;
        logic [7:0] ex;
        for (int i = 0; i < 256; i++) begin
            ai = 4'(i >> 4);
            bi = 4'(i);
            ex = {4'b0, ai} * {4'b0, bi};
            run_op(1'b0, ai, bi, ex, 7);
        end
    endtask

    task automatic test_back_to_back();
        int cyc, bcyc;
        bit got;
        pulse_start(1'b0, 4'd3, 4'd5);
        @(negedge clk);
        a = 4'd2; b = 4'd2; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        wait_done(cyc, bcyc, got);
        n_total++;
        if (!got || prod0 !== 8'd15 || ia0 !== 4'd3 || ib0 !== 4'd5)
            $display("FAIL start_while_busy: got done=%b prod=%0d ia=%0d ib=%0d required 1 15 3 5",
                     got, prod0, ia0, ib0);
        else n_pass++;
        // Still in the done cycle: this start must be taken.
        a = 4'd2; b = 4'd2; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        wait_done(cyc, bcyc, got);
        n_total++;
        if (!got || cyc !== 7 || prod0 !== 8'd4)
            $display("FAIL start_in_done: got done=%b lat=%0d prod=%0d required 1 7 4", got, cyc, prod0);
        else n_pass++;
    endtask

    task automatic test_abort();
        bit seen;
        pulse_start(1'b0, 4'd7, 4'd7);
        repeat (3) @(negedge clk);
        abort0 = 1'b1;
        @(negedge clk);
        abort0 = 1'b0;
        n_total++;
        if (busy0 !== 1'b0 || done0 !== 1'b0 || st0 !== 2'd0)
            $display("FAIL abort_mid: got busy=%b done=%b st=%0d required 0 0 0", busy0, done0, st0);
        else n_pass++;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (done0) seen = 1'b1;
        end
        n_total++;
        if (seen || prod0 !== 8'd4 || ia0 !== 4'd7)
            $display("FAIL abort_hold: got done_seen=%b prod=%0d ia=%0d required 0 4 7", seen, prod0, ia0);
        else n_pass++;

        pulse_start(1'b0, 4'd6, 4'd6);
        repeat (6) @(negedge clk);
        abort0 = 1'b1;
        @(negedge clk);
        abort0 = 1'b0;
        n_total++;
        if (done0 !== 1'b0 || busy0 !== 1'b0 || prod0 !== 8'd4)
            $display("FAIL abort_last_col: got done=%b busy=%b prod=%0d required 0 0 4", done0, busy0, prod0);
        else n_pass++;

        abort0 = 1'b1;
        @(negedge clk);
        abort0 = 1'b0;
        @(negedge clk);
        n_total++;
        if (busy0 !== 1'b0 || prod0 !== 8'd4 || ia0 !== 4'd6)
            $display("FAIL abort_idle: got busy=%b prod=%0d ia=%0d required 0 4 6", busy0, prod0, ia0);
        else n_pass++;
        run_op(1'b0, 4'd5, 4'd6, 8'd30, 7);
    endtask

    task automatic test_reset_mid_op();
        bit seen;
        pulse_start(1'b0, 4'd15, 4'd15);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_vals("reset_mid");
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (done0 || busy0) seen = 1'b1;
        end
        n_total++;
        if (seen) $display("FAIL reset_mid_quiet: got activity after reset, required none");
        else n_pass++;
    endtask

    task automatic test_pp_reg();
        logic [11:0] exp_ctrl;
        int c;
        pulse_start(1'b1, 4'd13, 4'd11);
        for (int k = 0; k < 14; k++) begin
            c = k / 2;
            for (int i = 0; i < 4; i++)
                exp_ctrl[i*3 +: 3] = (c >= i && c - i <= 3) ? 3'(c - i) : 3'd4;
            n_total++;
            if ({c13, c12, c11, c10} !== exp_ctrl || done1 !== 1'b0)
                $display("FAIL pp_reg_ctrl k=%0d: got %h done=%b required %h done=0",
                         k, {c13, c12, c11, c10}, done1, exp_ctrl);
            else n_pass++;
            @(negedge clk);
        end
        n_total++;
        if (done1 !== 1'b1 || prod1 !== 8'd143 || busy1 !== 1'b0)
            $display("FAIL pp_reg_13x11: got done=%b prod=%0d busy=%b required 1 143 0", done1, prod1, busy1);
        else n_pass++;
        run_op(1'b1, 4'd15, 4'd15, 8'd225, 14);
        run_op(1'b1, 4'd9, 4'd1, 8'd9, 14);
        run_op(1'b1, 4'd0, 4'd7, 8'd0, 14);
    endtask

    initial begin
        n_pass = 0; n_total = 0;
        sel = 1'b0; rst_n = 1'b0;
        start0 = 1'b0; start1 = 1'b0; abort0 = 1'b0; abort1 = 1'b0;
        a = 4'd0; b = 4'd0;
        test_reset();
        test_basic();
        test_exhaustive();
        test_back_to_back();
        test_abort();
        test_reset_mid_op();
        test_pp_reg();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
